// File: rtl/lcd_timing.sv
// ---------------------------------------------------------------------------
// lcd_timing
//   Raster timing generator and pixel-fetch sequencer for the badge LCD.
//   Free-running horizontal/vertical counters walk the active, front-porch,
//   sync and back-porch intervals. Fetch requests are issued for the pixel
//   under the counters. The region flags travel down a LATENCY-deep delay
//   line so that DE/sync reach the panel in step with the fetched colour.
//
// Ports
//   clock        in   pixel clock
//   reset        in   synchronous, active-high
//   req_valid    out  fetch request (active region only)
//   req_x/req_y  out  pixel coordinate being requested (h, v)
//   line_start   out  one-clock pulse at h=0 of every visible line
//   frame_start  out  one-clock pulse at h=0, v=0
//   rgb_in       in   RGB565 pixel, valid LATENCY clocks after its request
//   lcd_de       out  panel data enable
//   lcd_hsync    out  panel hsync (HS_POL level while asserted)
//   lcd_vsync    out  panel vsync (VS_POL level while asserted)
//   lcd_rgb      out  panel pixel, forced to 0 outside DE
// ---------------------------------------------------------------------------
module lcd_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned LATENCY  = 2,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 10
) (
  input  logic           clock,
  input  logic           reset,
  output logic           req_valid,
  output logic [X_W-1:0] req_x,
  output logic [Y_W-1:0] req_y,
  output logic           line_start,
  output logic           frame_start,
  input  logic [15:0]    rgb_in,
  output logic           lcd_de,
  output logic           lcd_hsync,
  output logic           lcd_vsync,
  output logic [15:0]    lcd_rgb
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sized interval bounds so every compare is between equal widths.
  localparam logic [X_W-1:0] H_LAST    = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_ACT_END = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_BEGIN  = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_END    = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0] V_LAST    = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_ACT_END = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_BEGIN  = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_END    = Y_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } region_t;

  // Element 0 is the youngest entry, element LATENCY-1 the oldest.
  typedef region_t [LATENCY-1:0] pipe_t;

  logic [X_W-1:0] h_q, h_d;
  logic [Y_W-1:0] v_q, v_d;
  region_t        region;
  region_t        dly;
  pipe_t          pipe_q, pipe_d;
  logic           lcd_de_q, lcd_de_d;
  logic           lcd_hsync_q, lcd_hsync_d;
  logic           lcd_vsync_q, lcd_vsync_d;
  logic [15:0]    lcd_rgb_q, lcd_rgb_d;

  // Raster counters: v advances only on the clock where h wraps.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    h_d = h_q + X_W'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + Y_W'(1);
    end
  end

  // Region decode on the registered counters. vsync spans whole lines, so
  // its edges fall on h=0 automatically.
  always_comb begin
    region     = '0;
    region.act = (h_q < H_ACT_END) && (v_q < V_ACT_END);
    region.hs  = (h_q >= HS_BEGIN) && (h_q < HS_END);
    region.vs  = (v_q >= VS_BEGIN) && (v_q < VS_END);
  end

  // Request side is combinational from the counters; while reset is held the
  // coordinate reads as (0,0) and the strobes are suppressed.
  always_comb begin
    req_valid   = region.act && !reset;
    req_x       = reset ? '0 : h_q;
    req_y       = reset ? '0 : v_q;
    line_start  = !reset && (h_q == '0) && (v_q < V_ACT_END);
    frame_start = !reset && (h_q == '0) && (v_q == '0);
  end

  // Delay line: shift the new region in at the bottom; the cast drops the
  // oldest entry, which also keeps LATENCY=1 legal.
  always_comb begin
    pipe_d = pipe_t'({pipe_q, region});
    dly    = pipe_q[LATENCY-1];
  end

  // Output stage: one more register after the delay line, so a request at
  // cycle t appears on the panel at t+LATENCY+1 with rgb_in from t+LATENCY.
  always_comb begin
    lcd_de_d    = dly.act;
    lcd_hsync_d = dly.hs ? HS_POL : ~HS_POL;
    lcd_vsync_d = dly.vs ? VS_POL : ~VS_POL;
    lcd_rgb_d   = dly.act ? rgb_in : 16'h0000;
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      h_q         <= '0;
      v_q         <= '0;
      // NOTE: the delay line is reset on purpose even though it is pure
      // pipeline; otherwise a mid-frame reset would leak stale DE/sync.
      pipe_q      <= '0;
      lcd_de_q    <= 1'b0;
      lcd_hsync_q <= ~HS_POL;
      lcd_vsync_q <= ~VS_POL;
      lcd_rgb_q   <= 16'h0000;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      pipe_q      <= pipe_d;
      lcd_de_q    <= lcd_de_d;
      lcd_hsync_q <= lcd_hsync_d;
      lcd_vsync_q <= lcd_vsync_d;
      lcd_rgb_q   <= lcd_rgb_d;
    end
  end

  assign lcd_de    = lcd_de_q;
  assign lcd_hsync = lcd_hsync_q;
  assign lcd_vsync = lcd_vsync_q;
  assign lcd_rgb   = lcd_rgb_q;

endmodule

// File: tb/tb_lcd_timing.sv
// ---------------------------------------------------------------------------
// tb_lcd_timing
//   Four lcd_timing instances share clock and reset:
//     l2 : default horizontal timing, short frame (V 4/1/1/1), LATENCY=2
//     l1 : as l2, LATENCY=1
//     l4 : as l2, LATENCY=4
//     sm : small raster H 4/1/2/1, V 3/1/1/1, LATENCY=2
//   A cycle-position model derives every output from n, the number of clock
//   edges since the last edge that sampled reset high. rgb_in carries the x
//   coordinate of the request made LATENCY clocks earlier (junk otherwise).
// ---------------------------------------------------------------------------
module tb_lcd_timing;

  typedef struct {
    int ha, hfp, hs, hbp;
    int va, vfp, vs, vbp;
    int lat;
  } cfg_t;

  typedef struct packed {
    logic        req_valid;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        ls;
    logic        fs;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic [15:0] rgb;
  } obs_t;

  cfg_t cfg_l2 = '{640, 16, 96, 48, 4, 1, 1, 1, 2};
  cfg_t cfg_l1 = '{640, 16, 96, 48, 4, 1, 1, 1, 1};
  cfg_t cfg_l4 = '{640, 16, 96, 48, 4, 1, 1, 1, 4};
  cfg_t cfg_sm = '{4, 1, 2, 1, 3, 1, 1, 1, 2};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n      = 0;
  bit known  = 1'b0;
  bit phase  = 1'b0;
  bit done   = 1'b0;

  // ---------------- DUT signals ----------------
  logic        l2_rv, l2_ls, l2_fs, l2_de, l2_hs, l2_vs;
  logic [9:0]  l2_x, l2_y;
  logic [15:0] l2_rgb_in = 16'hFFFF, l2_rgb;
  logic        l1_rv, l1_ls, l1_fs, l1_de, l1_hs, l1_vs;
  logic [9:0]  l1_x, l1_y;
  logic [15:0] l1_rgb_in = 16'hFFFF, l1_rgb;
  logic        l4_rv, l4_ls, l4_fs, l4_de, l4_hs, l4_vs;
  logic [9:0]  l4_x, l4_y;
  logic [15:0] l4_rgb_in = 16'hFFFF, l4_rgb;
  logic        sm_rv, sm_ls, sm_fs, sm_de, sm_hs, sm_vs;
  logic [9:0]  sm_x, sm_y;
  logic [15:0] sm_rgb_in = 16'hFFFF, sm_rgb;

  lcd_timing #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .LATENCY(2)) u_l2 (
    .clock(clk), .reset(reset), .req_valid(l2_rv), .req_x(l2_x), .req_y(l2_y),
    .line_start(l2_ls), .frame_start(l2_fs), .rgb_in(l2_rgb_in), .lcd_de(l2_de),
    .lcd_hsync(l2_hs), .lcd_vsync(l2_vs), .lcd_rgb(l2_rgb));

  lcd_timing #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .LATENCY(1)) u_l1 (
    .clock(clk), .reset(reset), .req_valid(l1_rv), .req_x(l1_x), .req_y(l1_y),
    .line_start(l1_ls), .frame_start(l1_fs), .rgb_in(l1_rgb_in), .lcd_de(l1_de),
    .lcd_hsync(l1_hs), .lcd_vsync(l1_vs), .lcd_rgb(l1_rgb));

  lcd_timing #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .LATENCY(4)) u_l4 (
    .clock(clk), .reset(reset), .req_valid(l4_rv), .req_x(l4_x), .req_y(l4_y),
    .line_start(l4_ls), .frame_start(l4_fs), .rgb_in(l4_rgb_in), .lcd_de(l4_de),
    .lcd_hsync(l4_hs), .lcd_vsync(l4_vs), .lcd_rgb(l4_rgb));

  lcd_timing #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
               .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .LATENCY(2)) u_sm (
    .clock(clk), .reset(reset), .req_valid(sm_rv), .req_x(sm_x), .req_y(sm_y),
    .line_start(sm_ls), .frame_start(sm_fs), .rgb_in(sm_rgb_in), .lcd_de(sm_de),
    .lcd_hsync(sm_hs), .lcd_vsync(sm_vs), .lcd_rgb(sm_rgb));

  // ---------------- model ----------------
  function automatic int h_total(cfg_t c);
    return c.ha + c.hfp + c.hs + c.hbp;
  endfunction

  function automatic int f_total(cfg_t c);
    return h_total(c) * (c.va + c.vfp + c.vs + c.vbp);
  endfunction

  // Expected outputs for a cycle n edges after reset; rst is the live reset.
  function automatic obs_t model(cfg_t c, int cyc, logic rst);
    obs_t o;
    int   p, h, v;
    o       = '0;
    o.hsync = 1'b1;
    o.vsync = 1'b1;
    if (!rst) begin
      p           = cyc % f_total(c);
      h           = p % h_total(c);
      v           = p / h_total(c);
      o.req_valid = (h < c.ha) && (v < c.va);
      o.x         = 10'(h);
      o.y         = 10'(v);
      o.ls        = (h == 0) && (v < c.va);
      o.fs        = (p == 0);
    end
    if (cyc >= c.lat + 1) begin
      p       = (cyc - c.lat - 1) % f_total(c);
      h       = p % h_total(c);
      v       = p / h_total(c);
      o.de    = (h < c.ha) && (v < c.va);
      o.hsync = !((h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hs));
      o.vsync = !((v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vs));
      o.rgb   = o.de ? 16'(h) : 16'h0000;
    end
    return o;
  endfunction

  // Upstream answer for cycle n: x of the request LATENCY clocks earlier.
  function automatic logic [15:0] rgb_for(cfg_t c, int cyc);
    int p, h, v;
    if (cyc < c.lat) return 16'hFFFF;
    p = (cyc - c.lat) % f_total(c);
    h = p % h_total(c);
    v = p / h_total(c);
    return ((h < c.ha) && (v < c.va)) ? 16'(h) : 16'hA5A5;
  endfunction

  task automatic finish_sim();
    if (!done) begin
      done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  endtask

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp(string name, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s n=%0d: got %h expected %h (rv,x,y,ls,fs,de,hs,vs,rgb)",
               name, n, act, exp);
      if (errors >= 50) finish_sim();
    end
  endtask

  // ---------------- cycle counter and upstream driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        n     = 0;
        known = 1'b1;
      end else begin
        n = n + 1;
      end
      #1;
      l2_rgb_in = rgb_for(cfg_l2, n);
      l1_rgb_in = rgb_for(cfg_l1, n);
      l4_rgb_in = rgb_for(cfg_l4, n);
      sm_rgb_in = rgb_for(cfg_sm, n);
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (known && !done) begin
      cmp("l2", {l2_rv, l2_x, l2_y, l2_ls, l2_fs, l2_de, l2_hs, l2_vs, l2_rgb},
          model(cfg_l2, n, reset));
      cmp("l1", {l1_rv, l1_x, l1_y, l1_ls, l1_fs, l1_de, l1_hs, l1_vs, l1_rgb},
          model(cfg_l1, n, reset));
      cmp("l4", {l4_rv, l4_x, l4_y, l4_ls, l4_fs, l4_de, l4_hs, l4_vs, l4_rgb},
          model(cfg_l4, n, reset));
      cmp("sm", {sm_rv, sm_x, sm_y, sm_ls, sm_fs, sm_de, sm_hs, sm_vs, sm_rgb},
          model(cfg_sm, n, reset));
    end
  end

  // ---------------- event statistics (free-running phase) ----------------
  int   l2_req_hi = 0, l2_req_lo = 0, l2_hs_low = 0, l2_max_y = 0;
  int   l2_de_rise[$], l2_hs_fall[$], l2_fs_n[$], sm_fs_n[$];
  int   sm_vs_low = 0, sm_ls_cnt = 0, sm_vs_fall = -1, sm_max_y = 0;
  int   l1_first = -1, l4_first = -1;
  logic l2_de_p = 1'b0, l2_hs_p = 1'b1, sm_vs_p = 1'b1;

  always @(negedge clk) begin
    if (phase) begin
      if (n < 800) begin
        if (l2_rv) l2_req_hi++;
        else       l2_req_lo++;
      end
      if (l2_de && !l2_de_p) l2_de_rise.push_back(n);
      if (!l2_hs && l2_hs_p) l2_hs_fall.push_back(n);
      if (!l2_hs && l2_hs_fall.size() == 1) l2_hs_low++;
      if (l2_fs) l2_fs_n.push_back(n);
      if (int'(l2_y) > l2_max_y) l2_max_y = int'(l2_y);
      if (sm_fs) sm_fs_n.push_back(n);
      if (n >= 48 && n < 96) begin
        if (!sm_vs) sm_vs_low++;
        if (sm_ls)  sm_ls_cnt++;
      end
      if (!sm_vs && sm_vs_p && sm_vs_fall < 0) sm_vs_fall = n;
      if (int'(sm_y) > sm_max_y) sm_max_y = int'(sm_y);
      if (l1_de && l1_first < 0) l1_first = n;
      if (l4_de && l4_first < 0) l4_first = n;
      l2_de_p = l2_de;
      l2_hs_p = l2_hs;
      sm_vs_p = sm_vs;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int rise;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_lcd_de", l2_de, 0);
    check("rst_lcd_rgb", l2_rgb, 0);
    check("rst_lcd_hsync", l2_hs, 1);
    check("rst_lcd_vsync", l2_vs, 1);
    check("rst_req_valid", l2_rv, 0);

    @(posedge clk);
    #1 reset = 1'b0;
    phase = 1'b1;
    @(negedge clk);
    check("first_req_valid", l2_rv, 1);
    check("first_frame_start", l2_fs, 1);
    check("first_line_start", l2_ls, 1);
    check("first_req_x", l2_x, 0);
    check("first_req_y", l2_y, 0);

    // Two full l2 frames plus part of a third, then reset at h=300, v=2.
    repeat (13100) @(posedge clk);
    #1 phase = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_req_valid", l2_rv, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_lcd_de", l2_de, 0);
    check("midrst_lcd_hsync", l2_hs, 1);
    check("midrst_frame_start", l2_fs, 1);
    rise = -1;
    for (int i = 0; i < 20; i++) begin
      if (l2_de && rise < 0) rise = n;
      @(negedge clk);
    end
    check("midrst_de_rise", rise, 3);

    // Horizontal timing, default line.
    check("line0_req_high", l2_req_hi, 640);
    check("line0_req_low", l2_req_lo, 160);
    check("de_rise_count_ok", l2_de_rise.size() >= 2, 1);
    if (l2_de_rise.size() >= 2) begin
      check("l2_first_de", l2_de_rise[0], 3);
      check("line_period", l2_de_rise[1] - l2_de_rise[0], 800);
    end
    check("hs_fall_count_ok", l2_hs_fall.size() >= 1, 1);
    if (l2_hs_fall.size() >= 1 && l2_de_rise.size() >= 1)
      check("hsync_offset", l2_hs_fall[0] - l2_de_rise[0], 656);
    check("hsync_width", l2_hs_low, 96);

    // Frame wrap on the l2 raster (800 x 7).
    check("l2_frame_count", l2_fs_n.size(), 3);
    if (l2_fs_n.size() >= 3) begin
      check("l2_frame_gap0", l2_fs_n[1] - l2_fs_n[0], 5600);
      check("l2_frame_gap1", l2_fs_n[2] - l2_fs_n[1], 5600);
    end
    check("l2_max_y", l2_max_y, 6);

    // Vertical timing on the small raster (8 x 6).
    check("sm_fs_count_ok", sm_fs_n.size() >= 3, 1);
    if (sm_fs_n.size() >= 3) begin
      check("sm_frame_gap0", sm_fs_n[1] - sm_fs_n[0], 48);
      check("sm_frame_gap1", sm_fs_n[2] - sm_fs_n[1], 48);
    end
    check("sm_vsync_low", sm_vs_low, 8);
    check("sm_vsync_start", sm_vs_fall, 35);
    check("sm_line_starts", sm_ls_cnt, 3);
    check("sm_max_y", sm_max_y, 5);

    // Latency alignment: first DE at LATENCY+1.
    check("l1_first_de", l1_first, 2);
    check("l4_first_de", l4_first, 5);

    finish_sim();
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    finish_sim();
  end

endmodule
